cmn_fifo: RTL and testbench

- Generic synchronous single-clock FIFO with show-ahead (first-word-fall-through) output.
- Used as the per-port write-request queue in the banked SRAM. Each entry packs {addr[13:0], data[31:0]}, so DW=46 and AW=8.
- The consumer sees the head entry on rdata whenever empty is low, and pulses re to pop it.

---
 rtl/cmn_fifo_mem.sv | 27 ++
 rtl/cmn_fifo.sv | 83 ++++++++
 tb/tb_cmn_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmn_fifo_mem.sv
// Storage array for cmn_fifo: synchronous write port, asynchronous (zero-latency) read port.
module cmn_fifo_mem #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int DEPTH = 1 << AW;

    // Contents are deliberately left unreset; only the pointers define validity.
    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmn_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers.
// Define CMN_FIFO_STATUS_EN to add the level/overflow/underflow status outputs.
module cmn_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    output logic [DW-1:0] rdata,
    output logic          full,
`ifdef CMN_FIFO_STATUS_EN
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow,
`endif
    output logic          empty
);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    // Both accept decisions use the pre-edge flags, so push and pop stay independent.
    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_push = we && !full;
    assign w_pop  = re && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    cmn_fifo_mem #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (rdata)
    );

`ifdef CMN_FIFO_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (we && full) begin
                r_overflow <= 1'b1;
            end
            if (re && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign level     = r_wptr - r_rptr;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_cmn_fifo.sv
// Directed self-checking bench for cmn_fifo (DW=46, AW=8).
// Status outputs are checked too when CMN_FIFO_STATUS_EN is defined.
module tb_cmn_fifo;

    localparam int DW = 46;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          we;
    logic [DW-1:0] wdata;
    logic          re;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
`ifdef CMN_FIFO_STATUS_EN
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmn_fifo #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .we        (we),
        .wdata     (wdata),
        .re        (re),
        .rdata     (rdata),
        .full      (full),
`ifdef CMN_FIFO_STATUS_EN
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .empty     (empty)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstn  = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        wdata = '0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state and pops on an empty FIFO.
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_full", 64'(full), 64'd0);
`ifdef CMN_FIFO_STATUS_EN
        check("reset_level", 64'(level), 64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
`endif
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_pop_empty", 64'(empty), 64'd1);
        end
        re = 1'b0;
`ifdef CMN_FIFO_STATUS_EN
        check("underflow_sticky", 64'(underflow), 64'd1);
`endif

        // Single push and pop.
        we    = 1'b1;
        wdata = 46'h0001_2345_6789;
        tick();
        we = 1'b0;
        check("single_empty", 64'(empty), 64'd0);
        check("single_rdata", 64'(rdata), 64'h0001_2345_6789);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("single_pop_empty", 64'(empty), 64'd1);

        // Fill to capacity, try an overflowing push, drain in order.
        we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wdata = DW'(i);
            tick();
            if (i == DEPTH - 2) check("almost_full", 64'(full), 64'd0);
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_head", 64'(rdata), 64'd0);
        wdata = DW'(999);
        tick();
        we = 1'b0;
        check("drop_full", 64'(full), 64'd1);
        check("drop_head", 64'(rdata), 64'd0);
`ifdef CMN_FIFO_STATUS_EN
        check("full_level", 64'(level), 64'd256);
        check("overflow_sticky", 64'(overflow), 64'd1);
`endif
        re = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(rdata), 64'(i));
            tick();
        end
        re = 1'b0;
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_full", 64'(full), 64'd0);

        // Steady-state streaming across pointer wrap at occupancy 10.
        we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = DW'(1000 + i);
            tick();
        end
        re = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wdata = DW'(1010 + k);
            check("stream_order", 64'(rdata), 64'(1000 + k));
            tick();
            check("stream_empty", 64'(empty), 64'd0);
            check("stream_full", 64'(full), 64'd0);
`ifdef CMN_FIFO_STATUS_EN
            check("stream_level", 64'(level), 64'd10);
`endif
        end
        we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stream_drain", 64'(rdata), 64'(1300 + i));
            tick();
        end
        re = 1'b0;
        check("stream_drained", 64'(empty), 64'd1);

        // Simultaneous push and pop while empty: only the push takes effect.
        we    = 1'b1;
        re    = 1'b1;
        wdata = 46'h5A;
        tick();
        we = 1'b0;
        re = 1'b0;
        check("empty_wr_rd_empty", 64'(empty), 64'd0);
        check("empty_wr_rd_rdata", 64'(rdata), 64'h5A);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("empty_wr_rd_popped", 64'(empty), 64'd1);

        // Simultaneous push and pop while full: only the pop takes effect.
        we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wdata = DW'(2000 + i);
            tick();
        end
        check("refill_full", 64'(full), 64'd1);
        re    = 1'b1;
        wdata = DW'(7777);
        tick();
        we = 1'b0;
        re = 1'b0;
        check("full_wr_rd_full", 64'(full), 64'd0);
        check("full_wr_rd_rdata", 64'(rdata), 64'd2001);
`ifdef CMN_FIFO_STATUS_EN
        check("full_wr_rd_level", 64'(level), 64'd255);
`endif

        // Reset in the middle of a fill; reset also dominates a concurrent push.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        we   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = DW'(3000 + i);
            tick();
        end
        check("partial_head", 64'(rdata), 64'd3000);
        rstn  = 1'b0;
        wdata = DW'(3999);
        tick();
        rstn = 1'b1;
        we   = 1'b0;
        check("mid_reset_empty", 64'(empty), 64'd1);
        check("mid_reset_full", 64'(full), 64'd0);
`ifdef CMN_FIFO_STATUS_EN
        check("mid_reset_level", 64'(level), 64'd0);
        check("mid_reset_overflow", 64'(overflow), 64'd0);
`endif
        we    = 1'b1;
        wdata = DW'(4000);
        tick();
        we = 1'b0;
        check("post_reset_rdata", 64'(rdata), 64'd4000);
        check("post_reset_empty", 64'(empty), 64'd0);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("post_reset_popped", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
